muldiv_unit: RTL and testbench

//  Multi-cycle RV32M/RV64M execute unit: all eight M-extension ops (MUL/MULH/MULHSU/MULHU,
//  DIV/DIVU/REM/REMU). Sits beside the ALU in EX and replaces the single-cycle multiplier.

---
 rtl/rv_m_pkg.sv | 45 ++++
 rtl/serial_divider.sv | 72 +++++++
 rtl/muldiv_unit.sv | 132 +++++++++++++
 tb/tb_muldiv_unit.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_m_pkg.sv
// rtl/rv_m_pkg.sv - RV M-extension funct3 codes, op-class helpers and execute-unit states
package rv_m_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  function automatic logic is_mul(input logic [2:0] op);
    return op < OP_DIV;
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return op >= OP_DIV;
  endfunction

  // Signedness of the divide class only; multiplies use the mul_*_signed helpers
  function automatic logic is_signed(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_rem(input logic [2:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic mul_a_signed(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU);
  endfunction

  function automatic logic mul_b_signed(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH);
  endfunction

endpackage

// File: rtl/serial_divider.sv
// rtl/serial_divider.sv - restoring divider, one quotient bit per edge on unsigned magnitudes
module serial_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(XLEN);

  logic [CW-1:0]   cnt_q;
  logic            running_q;
  logic            done_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] dvs_q;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // Dividend bits shift out of the quotient register into the partial remainder
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, dvs_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running_q <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        running_q <= 1'b0;
      end else if (start) begin
        quo_q     <= dividend;
        rem_q     <= '0;
        dvs_q     <= divisor;
        cnt_q     <= CW'(XLEN - 1);
        running_q <= 1'b1;
      end else if (running_q) begin
        if (diff[XLEN]) begin
          rem_q <= shifted[XLEN-1:0];
          quo_q <= {quo_q[XLEN-2:0], 1'b0};
        end else begin
          rem_q <= diff[XLEN-1:0];
          quo_q <= {quo_q[XLEN-2:0], 1'b1};
        end
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == '0) begin
          running_q <= 1'b0;
          done_q    <= 1'b1;
        end
      end
    end
  end

  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle RV32M/RV64M multiply/divide unit beside the EX-stage ALU
module muldiv_unit
  import rv_m_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 2,
  parameter int REG_ADDR_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            op,
  input  logic [XLEN-1:0]       rs1_val,
  input  logic [XLEN-1:0]       rs2_val,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       result,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic                  busy
);

  localparam int MCW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e             state_q, state_d, target;
  logic                  accept, fast, div_start, div_done;
  logic [2:0]            op_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  qneg_q, rneg_q;
  logic [MCW-1:0]        mcnt_q;
  logic [XLEN-1:0]       fast_res, mag_a, mag_b, div_quo, div_rem, div_res;
  logic [2*XLEN-1:0]     ext_a, ext_b, product;
  logic [2*XLEN-1:0]     prod_q [MUL_LATENCY];

  // Extending to 2*XLEN gives the same low 2*XLEN bits as an (XLEN+1)-bit signed product
  always_comb begin
    ext_a    = {{XLEN{mul_a_signed(op) & rs1_val[XLEN-1]}}, rs1_val};
    ext_b    = {{XLEN{mul_b_signed(op) & rs2_val[XLEN-1]}}, rs2_val};
    product  = ext_a * ext_b;
    mag_a    = (is_signed(op) && rs1_val[XLEN-1]) ? -rs1_val : rs1_val;
    mag_b    = (is_signed(op) && rs2_val[XLEN-1]) ? -rs2_val : rs2_val;
    fast     = is_div(op) && ((rs2_val == '0) ||
               (is_signed(op) && (rs1_val == SMIN) && (rs2_val == '1)));
    if (rs2_val == '0) fast_res = is_rem(op) ? rs1_val : '1;
    else               fast_res = is_rem(op) ? '0 : rs1_val;
    div_res  = is_rem(op_q) ? (rneg_q ? -div_rem : div_rem)
                            : (qneg_q ? -div_quo : div_quo);
    target   = is_mul(op) ? ST_MUL : (fast ? ST_DONE : ST_DIV);
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q != ST_IDLE);
    accept    = in_valid && in_ready && !flush;
    div_start = accept && is_div(op) && !fast;
    state_d   = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = target;
      ST_MUL:  if (mcnt_q == '0) state_d = ST_DONE;
      ST_DIV:  if (div_done) state_d = ST_DONE;
      ST_DONE: begin
        if (accept)         state_d = target;
        else if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      rd_q   <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      mcnt_q <= '0;
      result <= '0;
      rd_out <= '0;
    end else if (accept) begin
      op_q   <= op;
      rd_q   <= rd_in;
      qneg_q <= is_signed(op) && (rs1_val[XLEN-1] ^ rs2_val[XLEN-1]);
      rneg_q <= is_signed(op) && rs1_val[XLEN-1];
      mcnt_q <= MCW'(MUL_LATENCY - 1);
      if (fast) begin
        result <= fast_res;
        rd_out <= rd_in;
      end
    end else if (!flush) begin
      if (state_q == ST_MUL) begin
        if (mcnt_q != '0) begin
          mcnt_q <= mcnt_q - 1'b1;
        end else begin
          result <= (op_q == OP_MUL) ? prod_q[MUL_LATENCY-1][XLEN-1:0]
                                     : prod_q[MUL_LATENCY-1][2*XLEN-1:XLEN];
          rd_out <= rd_q;
        end
      end else if ((state_q == ST_DIV) && div_done) begin
        result <= div_res;
        rd_out <= rd_q;
      end
    end
  end

  // Product register chain; synthesis may retime the multiplier across these stages
  always_ff @(posedge clk) begin
    if (accept) prod_q[0] <= product;
    for (int i = 1; i < MUL_LATENCY; i++) prod_q[i] <= prod_q[i-1];
  end

  serial_divider #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .abort     (flush),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized scoreboard bench for muldiv_unit against an arithmetic model
module tb_muldiv_unit;

  localparam int XLEN = 32;
  localparam int MUL_LATENCY = 2;
  localparam logic [31:0] SMIN = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = '0;
  logic [31:0] rs1_val = '0;
  logic [31:0] rs2_val = '0;
  logic [4:0]  rd_in = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        busy;

  muldiv_unit #(.XLEN(XLEN), .MUL_LATENCY(MUL_LATENCY), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_in(rd_in), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .rd_out(rd_out),
    .busy(busy)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   rdy_mode = 2;
  bit   seen = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got timeout/unexpected event expected none", name);
  endtask

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    int          ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    ia = a;
    ib = b;
    case (o)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == SMIN && b == 32'hFFFF_FFFF) return a;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == SMIN && b == 32'hFFFF_FFFF) return 0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o < 3'd4) return MUL_LATENCY;
    if (b == 0) return 0;
    if ((o == 3'd4 || o == 3'd6) && a == SMIN && b == 32'hFFFF_FFFF) return 0;
    return XLEN + 1;
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return SMIN;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] r);
    exp_t e;
    int   n;
    @(negedge clk);
    in_valid = 1'b1; op = o; rs1_val = a; rs2_val = b; rd_in = r;
    n = 0;
    forever begin
      #1;
      if (in_ready && !flush) begin
        e.res = model(o, a, b);
        e.rd  = r;
        e.lat = exp_lat(o, a, b);
        e.acc = cyc + 1;
        sb_q.push_back(e);
        break;
      end
      n++;
      if (n > 300) begin
        fail("issue_timeout");
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) fail("drain_timeout");
  endtask

  initial forever begin
    @(negedge clk);
    case (rdy_mode)
      1: out_ready = 1'b0;
      2: out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: latency checked on the first valid cycle, value checked on retire
  initial forever begin
    exp_t e;
    @(negedge clk);
    #2;
    if (rst_n && !flush && out_valid) begin
      if (sb_q.size() == 0) begin
        fail("unexpected_out");
      end else begin
        if (!seen) begin
          seen = 1'b1;
          chk("latency", 64'(cyc - sb_q[0].acc), 64'(sb_q[0].lat));
        end
        if (out_ready) begin
          e = sb_q.pop_front();
          seen = 1'b0;
          chk("result", 64'(result), 64'(e.res));
          chk("rd_out", 64'(rd_out), 64'(e.rd));
        end
      end
    end
  end

  initial begin
    logic [31:0] a, b;
    logic [31:0] hold_exp;
    int          n;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_result", 64'(result), 64'd0);
    chk("reset_rd_out", 64'(rd_out), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);

    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1);
    issue(3'd1, SMIN, SMIN, 5'd2);
    issue(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3);
    issue(3'd3, 32'hFFFF_FFFF, 32'd2, 5'd4);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6);
    issue(3'd5, 32'd200, 32'd20, 5'd7);
    issue(3'd4, 32'd1234, 32'd0, 5'd8);
    issue(3'd7, 32'd5, 32'd0, 5'd9);
    issue(3'd4, SMIN, 32'hFFFF_FFFF, 5'd10);
    issue(3'd6, SMIN, 32'hFFFF_FFFF, 5'd11);
    drain();

    rdy_mode = 0;
    repeat (250) begin
      a = rnd_val();
      b = rnd_val();
      issue(3'($urandom_range(0, 7)), a, b, 5'($urandom_range(0, 31)));
    end
    rdy_mode = 2;
    drain();

    rdy_mode = 1;
    a = $urandom;
    b = $urandom;
    hold_exp = model(3'd0, a, b);
    issue(3'd0, a, b, 5'd12);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!out_valid) fail("hold_wait_valid");
    repeat (5) begin
      @(negedge clk);
      #1;
      chk("hold_result", 64'(result), 64'(hold_exp));
      chk("hold_out_valid", 64'(out_valid), 64'd1);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    rdy_mode = 2;
    drain();

    issue(3'd4, 32'hFFFF_FF9C, 32'd7, 5'd13);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    sb_q.delete();
    seen = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    issue(3'd0, 32'd11, 32'd13, 5'd14);
    drain();
    repeat (40) @(negedge clk);

    issue(3'd5, 32'd1000, 32'd3, 5'd15);
    repeat (5) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    sb_q.delete();
    seen = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    issue(3'd6, 32'd1000, 32'd3, 5'd16);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: got no end of test expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
